// File: rtl/tb_handshake_sender_if.sv
`default_nettype none
// ============================================================================
// tb_handshake_sender_if : req/ack/data bundle between sender and receiver
// Rev 1.0
// ============================================================================
interface tb_handshake_sender_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             req;
    logic             ack;

    modport master (output data, output req, input  ack);
    modport slave  (input  data, input  req, output ack);
endinterface
`default_nettype wire

// File: rtl/tb_handshake_sender.sv
`default_nettype none
// ============================================================================
// tb_handshake_sender : incrementing-data req/ack sender, LFSR gaps, timeout
// Rev 1.0
// ============================================================================
module tb_handshake_sender #(
    parameter int          WIDTH       = 8,
    parameter int          GAP_W       = 8,
    parameter int          MODE        = 0,
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMEOUT     = 1000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_start,
    input  wire logic [GAP_W-1:0] i_gap_from,
    input  wire logic [GAP_W-1:0] i_gap_to,
    tb_handshake_sender_if.master hs,
    output logic                  o_busy,
    output logic [15:0]           o_sent_cnt,
    output logic                  o_timeout
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_GAP      = 2'd1;
    localparam logic [1:0] S_WAIT_ACK = 2'd2;
    localparam logic [1:0] S_WAIT_REL = 2'd3;

    localparam bit                  c_TOGGLE    = (MODE != 0);
    localparam int                  c_WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = c_WAIT_W'(TIMEOUT);
    localparam logic [15:0]         c_LFSR_TAPS = 16'hB400;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_ack_s;
    logic [15:0]            r_lfsr;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [GAP_W-1:0]       w_span;
    logic [GAP_W-1:0]       w_rnd;
    logic [GAP_W-1:0]       w_gap;
    logic [c_WAIT_W-1:0]    r_wait_cnt;
    logic [WIDTH-1:0]       r_data;
    logic                   r_req;
    logic [15:0]            r_sent_cnt;
    logic                   r_timeout;
    logic                   w_load_gap;
    logic                   w_launch;
    logic                   w_release;
    logic                   w_done;
    logic                   w_waiting;

    assign w_ack_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_lfsr <= SEED;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], hs.ack};
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);
        end
    end

    // Random offset is clamped to the span rather than reduced modulo it.
    assign w_span = i_gap_to - i_gap_from;
    assign w_rnd  = r_lfsr[GAP_W-1:0];
    assign w_gap  = (i_gap_to <= i_gap_from) ? i_gap_from
                  : i_gap_from + ((w_rnd <= w_span) ? w_rnd : w_span);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == '0) w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK, S_WAIT_REL: begin
                if (w_done)         w_state_nxt = i_start ? S_GAP : S_IDLE;
                else if (w_release) w_state_nxt = S_WAIT_REL;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_launch   = (r_state == S_GAP) && (r_gap_cnt == '0);
        w_release  = !c_TOGGLE && (r_state == S_WAIT_ACK) && w_ack_s;
        w_done     = c_TOGGLE ? ((r_state == S_WAIT_ACK) && (w_ack_s == r_req))
                              : ((r_state == S_WAIT_REL) && !w_ack_s);
        w_load_gap = i_start && ((r_state == S_IDLE) || w_done);
        w_waiting  = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_REL);
        o_busy     = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt  <= '0;
            r_wait_cnt <= '0;
            r_data     <= '0;
            r_req      <= 1'b0;
            r_sent_cnt <= 16'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_load_gap) begin
                r_gap_cnt <= w_gap;
            end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            // Each phase change re-arms the timeout; the counter saturates at the limit.
            if (w_launch) begin
                r_data     <= r_data + 1'b1;
                r_req      <= c_TOGGLE ? ~r_req : 1'b1;
                r_wait_cnt <= '0;
            end else if (w_release) begin
                r_req      <= 1'b0;
                r_wait_cnt <= '0;
            end else if (w_waiting && (TIMEOUT != 0) && (r_wait_cnt != c_WAIT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
                r_timeout  <= (r_wait_cnt == c_WAIT_MAX - 1'b1);
            end
            if (w_done) r_sent_cnt <= r_sent_cnt + 16'd1;
        end
    end

    assign hs.data    = r_data;
    assign hs.req     = r_req;
    assign o_sent_cnt = r_sent_cnt;
    assign o_timeout  = r_timeout;
endmodule
`default_nettype wire
